// File: rtl/lfsr_voice_mixer.sv
// Eight-voice LFSR noise mixer: envelope FSM per key, sequential 11-bit mix and 8-bit PWM output.
// Optional KEY_SYNC_EN inserts a 2-flop synchronizer on each key bit.
module lfsr_voice_mixer #(
    parameter int unsigned SAMPLE_DIV   = 256,
    parameter int unsigned ENV_STEP_DIV = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key,
    input  logic [63:0] lfsr_bus,
    output logic [7:0]  lfsr_en,
    output logic [10:0] sample_out,
    output logic        sample_valid,
    output logic        pwm_out
);

    localparam int unsigned DivW    = $clog2(SAMPLE_DIV);
    localparam int unsigned EnvDivW = (ENV_STEP_DIV > 1) ? $clog2(ENV_STEP_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StAttack, StSustain, StRelease} voice_st_e;

    logic [DivW-1:0]    div_q;
    logic [EnvDivW-1:0] env_div_q;
    voice_st_e          st_q [8];
    logic [3:0]         env_q [8];
    logic [3:0]         env_inc [8];
    logic [3:0]         env_dec [8];
    logic [7:0]         lfsr_en_q;
    logic               mix_busy_q;
    logic [2:0]         mix_idx_q;
    logic [10:0]        acc_q;
    logic [10:0]        sample_out_q;
    logic               sample_valid_q;
    logic [7:0]         pwm_cnt_q;
    logic [7:0]         pwm_cmp_q;
    logic [7:0]         key_eff;
    logic               tick;
    logic               pre_tick;
    logic               env_step;
    logic [11:0]        prod;
    logic [7:0]         term;

`ifdef KEY_SYNC_EN
    logic [7:0] key_s1_q;
    logic [7:0] key_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q <= '0;
            key_s2_q <= '0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
        end
    end

    assign key_eff = key_s2_q;
`else
    assign key_eff = key;
`endif

    assign tick     = (div_q == DivW'(SAMPLE_DIV - 1));
    assign pre_tick = (div_q == DivW'(SAMPLE_DIV - 2));
    assign env_step = tick && (env_div_q == EnvDivW'(ENV_STEP_DIV - 1));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            env_inc[i] = (env_q[i] == 4'd15) ? 4'd15 : env_q[i] + 4'd1;
            env_dec[i] = (env_q[i] == 4'd0) ? 4'd0 : env_q[i] - 4'd1;
        end
    end

    // One voice term per mix cycle; the >>4 scales byte*env back into 8 bits.
    always_comb begin
        prod = 12'(lfsr_bus[{mix_idx_q, 3'b000} +: 8]) * 12'(env_q[mix_idx_q]);
        term = (st_q[mix_idx_q] == StIdle) ? 8'd0 : 8'(prod >> 4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q          <= '0;
            env_div_q      <= '0;
            lfsr_en_q      <= '0;
            mix_busy_q     <= 1'b0;
            mix_idx_q      <= '0;
            acc_q          <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            pwm_cnt_q      <= '0;
            pwm_cmp_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                st_q[i]  <= StIdle;
                env_q[i] <= '0;
            end
        end else begin
            div_q <= tick ? '0 : div_q + DivW'(1);
            if (tick) begin
                env_div_q <= env_step ? '0 : env_div_q + EnvDivW'(1);
            end

            for (int i = 0; i < 8; i++) begin
                // State is stable from pre_tick through the tick cycle, so the strobe
                // reflects the voice state seen during the tick.
                lfsr_en_q[i] <= pre_tick && (st_q[i] != StIdle);
                if (env_step) begin
                    if (st_q[i] == StIdle) begin
                        if (key_eff[i]) begin
                            env_q[i] <= 4'd1;
                            st_q[i]  <= StAttack;
                        end
                    end else if (key_eff[i]) begin
                        env_q[i] <= env_inc[i];
                        st_q[i]  <= (env_inc[i] == 4'd15) ? StSustain : StAttack;
                    end else begin
                        env_q[i] <= env_dec[i];
                        st_q[i]  <= (env_dec[i] == 4'd0) ? StIdle : StRelease;
                    end
                end
            end

            sample_valid_q <= 1'b0;
            if (tick) begin
                mix_busy_q <= 1'b1;
                mix_idx_q  <= '0;
                acc_q      <= '0;
            end else if (mix_busy_q) begin
                acc_q     <= acc_q + 11'(term);
                mix_idx_q <= mix_idx_q + 3'd1;
                if (mix_idx_q == 3'd7) begin
                    mix_busy_q     <= 1'b0;
                    sample_out_q   <= acc_q + 11'(term);
                    sample_valid_q <= 1'b1;
                end
            end

            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                pwm_cmp_q <= sample_out_q[10:3];
            end
        end
    end

    assign lfsr_en      = lfsr_en_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign pwm_out      = (pwm_cnt_q < pwm_cmp_q);

endmodule

// File: tb/tb_lfsr_voice_mixer.sv
// Bench for lfsr_voice_mixer: cycle model with a sample scoreboard plus directed phase checks.
module tb_lfsr_voice_mixer;

    localparam int unsigned SD  = 16;
    localparam int unsigned ESD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key;
    logic [63:0] lfsr_bus;
    logic [7:0]  lfsr_en;
    logic [10:0] sample_out;
    logic        sample_valid;
    logic        pwm_out;

    always #5 clk = ~clk;

    lfsr_voice_mixer #(
        .SAMPLE_DIV   (SD),
        .ENV_STEP_DIV (ESD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .lfsr_bus     (lfsr_bus),
        .lfsr_en      (lfsr_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .pwm_out      (pwm_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state, describing the cycle currently being observed.
    typedef struct {int due; int val;} exp_t;
    exp_t sb[$];
    int   m_div = 0, m_ecnt = 0, m_steps = 0, m_cyc = 0, m_tick_cyc = 0;
    int   m_st[8];   // 0 idle, 1 attack, 2 sustain, 3 release
    int   m_env[8];
    bit   m_mix = 0;
    int   m_idx = 0, m_acc = 0, m_sample = 0, m_pcnt = 0, m_cmp = 0;
`ifdef KEY_SYNC_EN
    logic [7:0] m_ks1 = '0, m_ks2 = '0;
`endif

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_st[i]  = 0;
            m_env[i] = 0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] en_exp;
        logic [7:0] k;
        m_cyc++;
        en_exp = '0;
        if (m_div == SD - 1) begin
            for (int i = 0; i < 8; i++) en_exp[i] = (m_st[i] != 0);
        end
        check_eq("lfsr_en", lfsr_en, en_exp);
        check_eq("pwm_out", pwm_out, (m_pcnt < m_cmp));
        if (sb.size() > 0 && sb[0].due == m_cyc) begin
            check_eq("sample_valid", sample_valid, 1);
            check_eq("sample_out", sample_out, sb[0].val);
            m_sample = sb[0].val;
            void'(sb.pop_front());
        end else begin
            check_eq("sample_valid", sample_valid, 0);
        end

        if (reset) begin
            m_div = 0; m_ecnt = 0; m_mix = 0; m_idx = 0; m_acc = 0;
            m_sample = 0; m_pcnt = 0; m_cmp = 0;
            for (int i = 0; i < 8; i++) begin
                m_st[i]  = 0;
                m_env[i] = 0;
            end
            sb.delete();
`ifdef KEY_SYNC_EN
            m_ks1 = '0; m_ks2 = '0;
`endif
        end else begin
            if (m_pcnt == 255) m_cmp = m_sample >> 3;
            m_pcnt = (m_pcnt + 1) % 256;

            if (m_mix) begin
                if (m_st[m_idx] != 0)
                    m_acc += (int'(lfsr_bus[m_idx*8 +: 8]) * m_env[m_idx]) >> 4;
                if (m_idx == 7) begin
                    sb.push_back('{due: m_tick_cyc + 9, val: m_acc});
                    m_mix = 0;
                end else begin
                    m_idx++;
                end
            end

`ifdef KEY_SYNC_EN
            k = m_ks2;
            m_ks2 = m_ks1;
            m_ks1 = key;
`else
            k = key;
`endif
            if (m_div == SD - 1) begin
                m_div = 0; m_mix = 1; m_idx = 0; m_acc = 0; m_tick_cyc = m_cyc;
                if (m_ecnt == ESD - 1) begin
                    m_ecnt = 0;
                    m_steps++;
                    for (int i = 0; i < 8; i++) begin
                        case (m_st[i])
                            0: if (k[i]) begin m_env[i] = 1; m_st[i] = 1; end
                            2: if (k[i]) m_env[i] = 15;
                               else begin m_env[i] = 14; m_st[i] = 3; end
                            default: begin
                                if (k[i]) begin
                                    if (m_env[i] < 15) m_env[i]++;
                                    m_st[i] = (m_env[i] == 15) ? 2 : 1;
                                end else begin
                                    if (m_env[i] > 0) m_env[i]--;
                                    m_st[i] = (m_env[i] == 0) ? 0 : 3;
                                end
                            end
                        endcase
                    end
                end else begin
                    m_ecnt++;
                end
            end else begin
                m_div++;
            end
        end
    end

    task automatic set_in(input logic [7:0] k, input logic [63:0] b);
        @(posedge clk); #2;
        key      = k;
        lfsr_bus = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_steps(input int n);
        int target = m_steps + n;
        for (int i = 0; i < n * ESD * SD * 2 + 100; i++) begin
            if (m_steps >= target) break;
            @(negedge clk); #1;
        end
        if (m_steps < target) check_eq("step_timeout", m_steps, target);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (sample_valid) break;
        end
        if (!sample_valid) check_eq("valid_timeout", sample_valid, 1);
    endtask

    initial begin
        int n;
        int highs;
        reset    = 1'b1;
        key      = 8'hFF;
        lfsr_bus = '1;

        // Reset with all keys down: outputs stay quiet, first strobe after the first step.
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_sample_out", sample_out, 0);
        check_eq("rst_sample_valid", sample_valid, 0);
        check_eq("rst_lfsr_en", lfsr_en, 0);
        check_eq("rst_pwm", pwm_out, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        for (n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (lfsr_en != 0) break;
        end
        check_eq("first_en", lfsr_en, 8'hFF);
        check_eq("first_en_cycle", n, 5 * SD - 1);

        // Single voice attack to sustain.
        do_reset();
        set_in(8'h01, 64'hFF);
        wait_steps(1);
        wait_valid();
        check_eq("attack_env1", sample_out, 15);
        wait_steps(14);
        wait_valid();
        check_eq("sustain_v0", sample_out, 239);

        // Full chord and PWM duty.
        set_in(8'hFF, '1);
        wait_steps(15);
        wait_valid();
        check_eq("chord", sample_out, 1912);
        repeat (300) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); #1;
            highs += int'(pwm_out);
        end
        check_eq("pwm_duty", highs, 239);

        // Release for 5 steps, then retrigger from the current level.
        set_in(8'hFE, '1);
        wait_steps(5);
        wait_valid();
        check_eq("release_env10", sample_out, 7 * 239 + ((255 * 10) >> 4));
        set_in(8'hFF, '1);
        wait_steps(1);
        wait_valid();
        check_eq("retrig_env11", sample_out, 7 * 239 + ((255 * 11) >> 4));
        wait_steps(1);
        wait_valid();
        check_eq("retrig_env12", sample_out, 7 * 239 + ((255 * 12) >> 4));
        wait_steps(3);
        wait_valid();
        check_eq("retrig_sustain", sample_out, 1912);

        // Release all the way to idle.
        set_in(8'hFE, '1);
        wait_steps(15);
        wait_valid();
        check_eq("idle_sample", sample_out, 7 * 239);
        for (n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (lfsr_en != 0) break;
        end
        check_eq("idle_en", lfsr_en, 8'hFE);

        // Reset in the middle of a mix.
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_eq("midmix_sample_out", sample_out, 0);
        check_eq("midmix_pwm", pwm_out, 0);
        check_eq("midmix_valid", sample_valid, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            highs += int'(sample_valid);
        end
        check_eq("midmix_no_valid", highs, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
